// File: rtl/arp_eth_tx_pad.sv
// ARP frame transmitter: latches one frame's fields, then emits the Ethernet header and the
// ARP body (optionally zero-padded to 46 bytes) as an AXI-stream payload, MSB-first byte order.
module arp_eth_tx_pad #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit PAD_ENABLE  = 1'b1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_frame_valid,
    output logic                   s_frame_ready,
    input  logic [47:0]            s_eth_dest_mac,
    input  logic [47:0]            s_eth_src_mac,
    input  logic [15:0]            s_eth_type,
    input  logic [15:0]            s_arp_htype,
    input  logic [15:0]            s_arp_ptype,
    input  logic [15:0]            s_arp_oper,
    input  logic [47:0]            s_arp_sha,
    input  logic [31:0]            s_arp_spa,
    input  logic [47:0]            s_arp_tha,
    input  logic [31:0]            s_arp_tpa,
    output logic                   m_eth_hdr_valid,
    input  logic                   m_eth_hdr_ready,
    output logic [47:0]            m_eth_dest_mac,
    output logic [47:0]            m_eth_src_mac,
    output logic [15:0]            m_eth_type,
    output logic [DATA_WIDTH-1:0]  m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_eth_payload_axis_tkeep,
    output logic                   m_eth_payload_axis_tvalid,
    input  logic                   m_eth_payload_axis_tready,
    output logic                   m_eth_payload_axis_tlast,
    output logic                   m_eth_payload_axis_tuser,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] tx_frame_count
);

    localparam int MAX_LEN = 46;
    localparam int ARP_LEN = 28;
    localparam int LEN     = PAD_ENABLE ? MAX_LEN : ARP_LEN;

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t                 state_q;
    logic [6:0]             ptr_q;
    logic                   busy_q, busy_d;
    logic                   ready_q;
    logic                   hdr_valid_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic [7:0]  body_q [MAX_LEN];
    logic [7:0]  body_d [MAX_LEN];
    logic [47:0] dest_q, src_q;
    logic [15:0] type_q;

    logic [8*ARP_LEN-1:0]  arp_vec;
    logic [DATA_WIDTH-1:0] tdata_c;
    logic [KEEP_WIDTH-1:0] tkeep_c;
    logic [6:0]            idx;
    logic                  last_c, frame_hs, beat_hs, hdr_hs, pay_done, hdr_done;

    assign frame_hs = s_frame_valid && ready_q;
    assign beat_hs  = (state_q == PAYLOAD) && m_eth_payload_axis_tready;
    assign hdr_hs   = hdr_valid_q && m_eth_hdr_ready;
    assign last_c   = (int'(ptr_q) + KEEP_WIDTH) >= LEN;
    assign pay_done = (state_q == IDLE) || (beat_hs && last_c);
    assign hdr_done = !hdr_valid_q || hdr_hs;

    always_comb begin
        busy_d = busy_q;
        if (frame_hs)
            busy_d = 1'b1;
        else if (busy_q && pay_done && hdr_done)
            busy_d = 1'b0;
    end

    assign arp_vec = {s_arp_htype, s_arp_ptype, 8'h06, 8'h04, s_arp_oper,
                      s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++)
            body_d[i] = (i < ARP_LEN) ? arp_vec[8*(ARP_LEN-1-i) +: 8] : 8'h00;
    end

    // Bytes past LEN on the final beat are masked and driven as zero
    always_comb begin
        tdata_c = '0;
        tkeep_c = '0;
        idx     = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            idx = ptr_q + 7'(b);
            if (int'(idx) < LEN) begin
                tdata_c[8*b +: 8] = body_q[idx[5:0]];
                tkeep_c[b]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (frame_hs) begin
            body_q <= body_d;
            dest_q <= s_eth_dest_mac;
            src_q  <= s_eth_src_mac;
            type_q <= s_eth_type;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            hdr_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= !busy_d;
            if (frame_hs)
                hdr_valid_q <= 1'b1;
            else if (hdr_hs)
                hdr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_hs) begin
                        state_q <= PAYLOAD;
                        ptr_q   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (beat_hs) begin
                        if (last_c) begin
                            state_q <= IDLE;
                            ptr_q   <= '0;
                            count_q <= count_q + 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 7'(KEEP_WIDTH);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_frame_ready             = ready_q;
    assign busy                      = busy_q;
    assign tx_frame_count            = count_q;
    assign m_eth_hdr_valid           = hdr_valid_q;
    assign m_eth_dest_mac            = dest_q;
    assign m_eth_src_mac             = src_q;
    assign m_eth_type                = type_q;
    assign m_eth_payload_axis_tvalid = (state_q == PAYLOAD);
    assign m_eth_payload_axis_tdata  = tdata_c;
    assign m_eth_payload_axis_tkeep  = KEEP_ENABLE ? tkeep_c : {KEEP_WIDTH{1'b1}};
    assign m_eth_payload_axis_tlast  = (state_q == PAYLOAD) && last_c;
    assign m_eth_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_arp_eth_tx_pad.sv
// Bench for arp_eth_tx_pad: 32-bit payload, padding on, 2-bit frame counter.
module tb_arp_eth_tx_pad;

    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam bit PAD = 1'b1;
    localparam int CW  = 2;
    localparam int LEN = PAD ? 46 : 28;
    localparam int NBEATS = (LEN + KW - 1) / KW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic s_frame_valid = 1'b0, s_frame_ready;
    logic [47:0] s_eth_dest_mac = '0, s_eth_src_mac = '0, s_arp_sha = '0, s_arp_tha = '0;
    logic [15:0] s_eth_type = '0, s_arp_htype = '0, s_arp_ptype = '0, s_arp_oper = '0;
    logic [31:0] s_arp_spa = '0, s_arp_tpa = '0;
    logic m_eth_hdr_valid, m_eth_hdr_ready = 1'b0;
    logic [47:0] m_eth_dest_mac, m_eth_src_mac;
    logic [15:0] m_eth_type;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic tvalid, tready = 1'b0, tlast, tuser, busy;
    logic [CW-1:0] count;

    arp_eth_tx_pad #(.DATA_WIDTH(DW), .PAD_ENABLE(PAD), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_frame_valid(s_frame_valid), .s_frame_ready(s_frame_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_arp_htype(s_arp_htype), .s_arp_ptype(s_arp_ptype), .s_arp_oper(s_arp_oper),
        .s_arp_sha(s_arp_sha), .s_arp_spa(s_arp_spa), .s_arp_tha(s_arp_tha), .s_arp_tpa(s_arp_tpa),
        .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .m_eth_payload_axis_tdata(tdata), .m_eth_payload_axis_tkeep(tkeep),
        .m_eth_payload_axis_tvalid(tvalid), .m_eth_payload_axis_tready(tready),
        .m_eth_payload_axis_tlast(tlast), .m_eth_payload_axis_tuser(tuser),
        .busy(busy), .tx_frame_count(count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cnt_model = 0;
    logic [47:0] e_dmac, e_smac, e_sha, e_tha;
    logic [15:0] e_type, e_htype, e_ptype, e_oper;
    logic [31:0] e_spa, e_tpa;
    logic [7:0]  exp_bytes [$];

    // Reference body: list of bytes in wire order, then padded
    function automatic void build_expected();
        exp_bytes = {};
        for (int i = 1; i >= 0; i--) exp_bytes.push_back(e_htype[8*i +: 8]);
        for (int i = 1; i >= 0; i--) exp_bytes.push_back(e_ptype[8*i +: 8]);
        exp_bytes.push_back(8'd6);
        exp_bytes.push_back(8'd4);
        for (int i = 1; i >= 0; i--) exp_bytes.push_back(e_oper[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_bytes.push_back(e_sha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(e_spa[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_bytes.push_back(e_tha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(e_tpa[8*i +: 8]);
        while (exp_bytes.size() < LEN) exp_bytes.push_back(8'h00);
    endfunction

    task automatic pick_fields(input bit directed);
        e_dmac = 48'({$urandom, $urandom}); e_smac = 48'({$urandom, $urandom});
        e_type = 16'h0806;
        e_htype = directed ? 16'h0001 : 16'($urandom);
        e_ptype = directed ? 16'h0800 : 16'($urandom);
        e_oper  = directed ? 16'h0002 : 16'($urandom);
        e_sha = 48'({$urandom, $urandom}); e_tha = 48'({$urandom, $urandom});
        e_spa = $urandom; e_tpa = $urandom;
        build_expected();
    endtask

    task automatic drive_fields(input bit garbage);
        s_eth_dest_mac = garbage ? 48'({$urandom, $urandom}) : e_dmac;
        s_eth_src_mac  = garbage ? 48'({$urandom, $urandom}) : e_smac;
        s_eth_type     = garbage ? 16'($urandom) : e_type;
        s_arp_htype    = garbage ? 16'($urandom) : e_htype;
        s_arp_ptype    = garbage ? 16'($urandom) : e_ptype;
        s_arp_oper     = garbage ? 16'($urandom) : e_oper;
        s_arp_sha      = garbage ? 48'({$urandom, $urandom}) : e_sha;
        s_arp_tha      = garbage ? 48'({$urandom, $urandom}) : e_tha;
        s_arp_spa      = garbage ? $urandom : e_spa;
        s_arp_tpa      = garbage ? $urandom : e_tpa;
    endtask

    // One complete frame: accept, then drain payload and header under the given back-pressure
    task automatic run_frame(input bit directed, input int hdr_delay, input bit rnd_ready);
        int beat, cyc;
        bit hdr_done, stalled;
        logic [DW-1:0] prev_data, exp_data;
        logic [KW-1:0] exp_keep;
        pick_fields(directed);
        @(negedge clk);
        total++; if (s_frame_ready !== 1'b1) begin bad++; $display("FAIL ready_before got=%b exp=1", s_frame_ready); end
        drive_fields(1'b0);
        s_frame_valid = 1'b1;
        @(negedge clk);
        s_frame_valid = 1'b0;
        total++; if ({busy, tvalid, m_eth_hdr_valid, s_frame_ready} !== 4'b1110) begin
            bad++; $display("FAIL accept_state got=%b exp=1110", {busy, tvalid, m_eth_hdr_valid, s_frame_ready}); end
        beat = 0; hdr_done = 0; stalled = 0; prev_data = '0;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (!busy) break;
            total++; if (s_frame_ready !== 1'b0) begin bad++; $display("FAIL ready_busy got=%b exp=0", s_frame_ready); end
            if (m_eth_hdr_valid) begin
                total++; if ({m_eth_dest_mac, m_eth_src_mac, m_eth_type} !== {e_dmac, e_smac, e_type}) begin
                    bad++; $display("FAIL hdr_fields got=%h exp=%h", {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, {e_dmac, e_smac, e_type}); end
            end
            if (tvalid && stalled) begin
                total++; if (tdata !== prev_data) begin bad++; $display("FAIL stall_data got=%h exp=%h", tdata, prev_data); end
            end
            if (tvalid && beat >= NBEATS) begin
                total++; bad++; $display("FAIL extra_beat got=%0d exp=%0d", beat + 1, NBEATS);
            end
            tready = rnd_ready ? 1'($urandom) : 1'b1;
            m_eth_hdr_ready = (cyc >= hdr_delay);
            s_frame_valid = 1'($urandom);
            drive_fields(1'b1);
            if (tvalid && tready && beat < NBEATS) begin
                exp_data = '0; exp_keep = '0;
                for (int j = 0; j < KW; j++)
                    if (beat * KW + j < LEN) begin
                        exp_data[8*j +: 8] = exp_bytes[beat * KW + j];
                        exp_keep[j] = 1'b1;
                    end
                total++; if ({tdata, tkeep, tlast, tuser} !== {exp_data, exp_keep, (beat == NBEATS - 1), 1'b0}) begin
                    bad++; $display("FAIL beat%0d got=%h/%h/%b exp=%h/%h/%b", beat, tdata, tkeep, tlast,
                                    exp_data, exp_keep, (beat == NBEATS - 1)); end
                if (directed && beat == 0) begin
                    total++; if (tdata !== 32'h0008_0100) begin bad++; $display("FAIL first_beat got=%h exp=00080100", tdata); end
                end
                beat++;
            end
            if (m_eth_hdr_valid && m_eth_hdr_ready) hdr_done = 1;
            stalled = tvalid && !tready;
            prev_data = tdata;
            @(negedge clk);
        end
        s_frame_valid = 1'b0; tready = 1'b0; m_eth_hdr_ready = 1'b0;
        if (cyc >= 600) begin total++; bad++; $display("FAIL frame_timeout got=busy exp=idle"); end
        cnt_model = (cnt_model + 1) % (1 << CW);
        total++; if (beat !== NBEATS) begin bad++; $display("FAIL beat_count got=%0d exp=%0d", beat, NBEATS); end
        total++; if (hdr_done !== 1'b1) begin bad++; $display("FAIL hdr_done got=%b exp=1", hdr_done); end
        total++; if (count !== CW'(cnt_model)) begin bad++; $display("FAIL frame_count got=%0d exp=%0d", count, cnt_model); end
        total++; if ({tvalid, m_eth_hdr_valid, s_frame_ready} !== 3'b001) begin
            bad++; $display("FAIL end_state got=%b exp=001", {tvalid, m_eth_hdr_valid, s_frame_ready}); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({s_frame_ready, m_eth_hdr_valid, tvalid, tlast, busy, count} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {s_frame_ready, m_eth_hdr_valid, tvalid, tlast, busy, count}); end
        rst_n = 1'b1;
        #1;
        total++; if (s_frame_ready !== 1'b0) begin bad++; $display("FAIL ready_at_release got=%b exp=0", s_frame_ready); end
        @(negedge clk);
        total++; if (s_frame_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", s_frame_ready); end
        cnt_model = 0;
    endtask

    task automatic test_directed();
        run_frame(1'b1, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(1'b0, 40, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 5; f++) run_frame(1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) run_frame(1'b0, int'($urandom_range(0, 20)), 1'b1);
    endtask

    task automatic test_mid_reset();
        int seen;
        pick_fields(1'b0);
        @(negedge clk);
        drive_fields(1'b0);
        s_frame_valid = 1'b1;
        @(negedge clk);
        s_frame_valid = 1'b0;
        tready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            if (tvalid) seen++;
            @(negedge clk);
        end
        tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({s_frame_ready, m_eth_hdr_valid, tvalid, tlast, busy, count} !== '0) begin
            bad++; $display("FAIL midreset_outputs got=%b exp=0", {s_frame_ready, m_eth_hdr_valid, tvalid, tlast, busy, count}); end
        @(negedge clk);
        rst_n = 1'b1;
        cnt_model = 0;
        run_frame(1'b0, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
